// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register feeding the ALU with RAW forwarding (`ID_EX_FWD_EN) and load-use bubbles
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [4:0]    id_shamt_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic [3:0]    id_alu_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_beq_bne_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          id_mem_to_reg_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_wdata_i,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [3:0]    alu_ctrl_o,
  output logic          beq_bne_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] rd_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          mem_to_reg_o,
  output logic          valid_o,
  output logic          hazard_o
);
  logic          v_q, alu_src_q, beq_bne_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]    shamt_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic [3:0]    alu_ctrl_q;
  logic          bubble, ctl_kill, rt_used, load_use;
  logic [DW-1:0] fwd_rs, fwd_rt;

  function automatic logic hit(input logic en, input logic [RW-1:0] dst, input logic [RW-1:0] src);
    return en & (dst != '0) & (dst == src);
  endfunction

  assign bubble   = flush_i | (~stall_i & hazard_o);
  assign ctl_kill = bubble | ~id_valid_i;
  assign rt_used  = ~id_alu_src_i | id_mem_write_i;

  // load in EX whose destination the ID instruction reads right now
  always_comb load_use = id_valid_i & mem_read_q & (hit(v_q, rd_q, id_rs_i) | (rt_used & hit(v_q, rd_q, id_rt_i)));

`ifdef ID_EX_FWD_EN
  // EX/MEM beats MEM/WB; register 0 never matches
  always_comb begin
    fwd_rs = hit(exmem_reg_write_i, exmem_rd_i, rs_q) ? exmem_result_i :
             hit(memwb_reg_write_i, memwb_rd_i, rs_q) ? memwb_wdata_i : rs_data_q;
    fwd_rt = hit(exmem_reg_write_i, exmem_rd_i, rt_q) ? exmem_result_i :
             hit(memwb_reg_write_i, memwb_rd_i, rt_q) ? memwb_wdata_i : rt_data_q;
  end
  assign hazard_o = load_use;
`else
  logic raw, ex_wr;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result_i, memwb_reg_write_i, memwb_rd_i, memwb_wdata_i, rs_q, rt_q};
  assign ex_wr      = v_q & reg_write_q;
  // without forwarding, any pending EX or EX/MEM write to a source register stalls ID; MEM/WB relies on write-before-read
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    raw    = id_valid_i & (hit(ex_wr, rd_q, id_rs_i) | hit(exmem_reg_write_i, exmem_rd_i, id_rs_i) |
             (rt_used & (hit(ex_wr, rd_q, id_rt_i) | hit(exmem_reg_write_i, exmem_rd_i, id_rt_i))));
  end
  assign hazard_o = load_use | raw;
`endif

  assign src1_o       = (alu_ctrl_q == 4'b0011) ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
  assign src2_o       = alu_src_q ? imm_q : fwd_rt;
  assign store_data_o = fwd_rt;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign beq_bne_o    = beq_bne_q;
  assign rd_o         = rd_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign valid_o      = v_q;

  // stage register: flush > stall > hazard bubble > load from ID
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      v_q          <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      beq_bne_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (bubble | ~stall_i) begin
      v_q          <= ~bubble & id_valid_i;
      rs_data_q    <= bubble ? '0 : id_rs_data_i;
      rt_data_q    <= bubble ? '0 : id_rt_data_i;
      imm_q        <= bubble ? '0 : id_imm_i;
      shamt_q      <= bubble ? '0 : id_shamt_i;
      rs_q         <= bubble ? '0 : id_rs_i;
      rt_q         <= bubble ? '0 : id_rt_i;
      rd_q         <= bubble ? '0 : id_rd_i;
      alu_ctrl_q   <= bubble ? '0 : id_alu_ctrl_i;
      alu_src_q    <= ~bubble & id_alu_src_i;
      beq_bne_q    <= ~bubble & id_beq_bne_i;
      reg_write_q  <= ~ctl_kill & id_reg_write_i;
      mem_read_q   <= ~ctl_kill & id_mem_read_i;
      mem_write_q  <= ~ctl_kill & id_mem_write_i;
      mem_to_reg_q <= ~ctl_kill & id_mem_to_reg_i;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the pipelined MIPS core. It sits directly upstream of the 32-bit ALU. It latches decoded ID-stage fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's `src1_i`, `src2_i`, `ctrl_i` and `BEQ_BNE` inputs, and detects load-use hazards, inserting a bubble for each.

## Interface
- `DW`, 32: datapath width.
- `RW`, 5: register-address width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `id_valid_i` in 1: ID holds a real instruction.
- `id_rs_data_i`, `id_rt_data_i` in DW: register-file read data.
- `id_imm_i` in DW: extended immediate.
- `id_shamt_i` in 5: shift amount.
- `id_rs_i`, `id_rt_i`, `id_rd_i` in RW: source and destination register numbers (`id_rd_i` is the already-selected write register).
- `id_alu_ctrl_i` in 4: ALU control code.
- `id_alu_src_i` in 1: 1 selects the immediate as src2.
- `id_beq_bne_i` in 1: branch flavour bit.
- `id_reg_write_i`, `id_mem_read_i`, `id_mem_write_i`, `id_mem_to_reg_i` in 1: control bits.
- `stall_i` in 1: hold the stage contents.
- `flush_i` in 1: kill the stage contents.
- `exmem_reg_write_i` in 1, `exmem_rd_i` in RW, `exmem_result_i` in DW: EX/MEM writeback info.
- `memwb_reg_write_i` in 1, `memwb_rd_i` in RW, `memwb_wdata_i` in DW: MEM/WB writeback info.
- `src1_o`, `src2_o` out DW: ALU operands (combinational from registers and forward inputs).
- `alu_ctrl_o` out 4, `beq_bne_o` out 1: to ALU.
- `store_data_o` out DW: forwarded rt value for stores.
- `rd_o` out RW; `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `valid_o` out 1: to EX/MEM.
- `hazard_o` out 1: ID must hold (load-use, or RAW when forwarding is compiled out).

## Operation
- Registered fields: valid, rs_data, rt_data, imm, shamt, rs, rt, rd, alu_ctrl, alu_src, beq_bne, and the four control bits.
- Per-edge update priority:
  1. `flush_i` loads a bubble.
  2. `stall_i` holds all fields.
  3. `hazard_o` loads a bubble.
  4. Otherwise the stage loads the ID fields.
- Bubble: valid=0, all control bits=0, alu_ctrl=0000, rs=rt=rd=0. Data fields are don't-care and are zeroed.
- A load with `id_valid_i`=0 also forces all control bits to 0.
- Forwarding for operand A (rs), per source register, applied independently to rs and rt:
  - If `exmem_reg_write_i` and `exmem_rd_i`≠0 and `exmem_rd_i`==rs, use `exmem_result_i`.
  - Else if the same conditions hold for MEM/WB, use `memwb_wdata_i`.
  - Else use the registered data.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- `src1_o` = {27'b0, shamt} when alu_ctrl==0011 (SLL: the ALU shifts src2 by src1[4:0]); otherwise fwd_rs.
- `src2_o` = imm when alu_src=1 (includes LUI, where the ALU uses src2[15:0]); otherwise fwd_rt.
- `store_data_o` = fwd_rt, always.
- Load-use: `hazard_o` = valid & mem_read & rd≠0 & (rd==`id_rs_i` | (rd==`id_rt_i` & ~`id_alu_src_i`|`id_mem_write_i`)), qualified by `id_valid_i`.

## Timing
- All outputs reset to 0. With every register at 0, `src1_o`/`src2_o`/`store_data_o` evaluate to 0 because rs=rt=0 blocks forwarding.
- Latency: ID fields appear on the outputs 1 cycle after the capturing edge. The forward path is purely combinational with zero added latency.
- Load-use case: `hazard_o` is high in the same cycle the conflicting instruction is in ID. The next edge inserts one bubble. At the following edge the load has left EX, `hazard_o` falls, and the instruction enters with MEM/WB forwarding.
- Stall and flush asserted together: flush wins.
- Stall with a pending hazard: contents are held and `hazard_o` stays asserted.
- Reset asserted mid-operation clears all state immediately, with no clock needed. The first edge after release loads normally.

## Configuration
- `ID_EX_FWD_EN` defined:
  - Forwarding muxes are present as described.
  - `hazard_o` flags load-use only.
- Undefined:
  - `src1_o`/`src2_o`/`store_data_o` use the registered data only.
  - `hazard_o` also asserts when a valid ID instruction reads a nonzero register equal to the EX-stage rd (reg_write=1) or to `exmem_rd_i` (with `exmem_reg_write_i`).
  - MEM/WB dependencies rely on register-file write-before-read.
  - A hazard inserts one bubble per cycle until it clears.

## Test plan
- Reset: rst_i low mid-run → all outputs 0 immediately. Release, then load `add` rs=3 (data 5), rt=4 (data 7) → next cycle `src1_o`=5, `src2_o`=7, `alu_ctrl_o`=0010, `valid_o`=1.
- Double forward: EX rs=8, exmem rd=8 result 0x11, memwb rd=8 wdata 0x22 → `src1_o`=0x11. Deassert `exmem_reg_write_i` → `src1_o`=0x22. With rs=0 and rd=0 → no forwarding, `src1_o`=0.
- Load-use: EX holds `lw` rd=9, ID reads rs=9 → `hazard_o`=1. Next cycle `valid_o`=0 and `reg_write_o`=0. Following cycle the instruction enters and `src1_o`=`memwb_wdata_i`.
- Stall/flush: stall_i=1 for 2 cycles → outputs unchanged. stall_i=flush_i=1 → bubble next cycle.
- SLL/LUI operands: alu_ctrl=0011, shamt=4, rt data 0x1 → `src1_o`=4, `src2_o`=1. LUI with imm=0x0000ABCD, alu_src=1 → `src2_o`=0x0000ABCD.
- With `ID_EX_FWD_EN` undefined: EX `add` rd=5 (reg_write) and ID reads rs=5 → `hazard_o`=1 and a bubble is inserted.
